// File: rtl/bram_axis_player.sv
// Pointer-driven BRAM-to-AXI-Stream playback engine with a credit-controlled output FIFO.
// Optional build macro PLAYER_TLAST_EN exposes m_axis_tlast on the stop-1 word of each loop.
module bram_axis_player #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 12,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [31:0]       start_ptr,
  input  logic [31:0]       stop_ptr,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
`ifdef PLAYER_TLAST_EN
  output logic              m_axis_tlast,
`endif
  output logic              busy,
  output logic              cfg_err,
  output logic [15:0]       wrap_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] stop_w;
  logic [ADDR_W-1:0] start_in;
  logic [ADDR_W-1:0] stop_in;
  logic              pair_ok;
  logic              go;
  logic              issue;
  logic              at_stop;
  logic              credit;
  logic [CW:0]       occupancy;

  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_end;
  logic [CW-1:0]     in_flight;

  logic [DATA_W-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_end;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;
  logic                  out_end;

  logic unused_ptr_bits;
  assign unused_ptr_bits = ^{start_ptr[31:ADDR_W+6], start_ptr[5:0],
                             stop_ptr[31:ADDR_W+6], stop_ptr[5:0]};

  assign start_in = start_ptr[ADDR_W+5:6];
  assign stop_in  = stop_ptr[ADDR_W+5:6];
  assign pair_ok  = stop_in > start_in;
  assign go       = (state == IDLE) && enable && !cfg_err && pair_ok;

  // Credits cover words already in the FIFO plus reads still inside the BRAM pipe.
  assign occupancy = {1'b0, count} + {1'b0, in_flight};
  assign credit    = occupancy < DEPTH_C;
  assign issue     = (state == RUN) && enable && credit;
  assign at_stop   = rd_ptr == (stop_w - ADDR_W'(1));

  assign bram_en   = issue;
  assign bram_addr = rd_ptr;
  assign busy      = state != IDLE;

  assign push          = pipe_v[RD_LAT-1];
  assign m_axis_tvalid = count != '0;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_idx] : '0;
  assign out_end       = m_axis_tvalid && mem_end[rd_idx];

`ifdef PLAYER_TLAST_EN
  assign m_axis_tlast = out_end;
`else
  // The loop-end tag stays internal and only drives wrap_cnt.
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      stop_w  <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (!enable) cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            rd_ptr <= start_in;
            stop_w <= stop_in;
            state  <= RUN;
          end else if (enable && !pair_ok) begin
            cfg_err <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            // Pointers are re-sampled at every wrap so GPIO edits take effect on the next loop.
            if (at_stop) begin
              if (pair_ok) begin
                rd_ptr <= start_in;
                stop_w <= stop_in;
              end else begin
                cfg_err <= 1'b1;
                state   <= DRAIN;
              end
            end else begin
              rd_ptr <= rd_ptr + ADDR_W'(1);
            end
          end
          if (!enable) state <= DRAIN;
        end
        DRAIN: begin
          if (in_flight == '0 && count == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v    <= '0;
      pipe_end  <= '0;
      in_flight <= '0;
      count     <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      mem_end   <= '0;
    end else begin
      pipe_v[0]   <= issue;
      pipe_end[0] <= issue && at_stop;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_end[i] <= pipe_end[i-1];
      end

      case ({issue, push})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase

      if (push) begin
        mem_end[wr_idx] <= pipe_end[RD_LAT-1];
        wr_idx          <= wr_idx + AW'(1);
      end
      if (pop) rd_idx <= rd_idx + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= bram_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_cnt <= '0;
    end else if (go) begin
      wrap_cnt <= '0;
    end else if (pop && out_end) begin
      wrap_cnt <= wrap_cnt + 16'd1;
    end
  end

endmodule
